// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel datapath, built on two read-first line memories.
// Optional macro SOBEL_WINDOW_SOF_EN adds sof_i for explicit start-of-frame resynchronisation.

module sync_ram_block #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  parameter int AW_P    = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW_P-1:0]    waddr_i,
  input  logic [WIDTH_P-1:0] wdata_i,
  input  logic               rd_en_i,
  input  logic [AW_P-1:0]    raddr_i,
  output logic [WIDTH_P-1:0] rdata_o
);
  logic [WIDTH_P-1:0] mem_r [DEPTH_P];

  // Read-first memory: a same-cycle write to the read address returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
    if (rd_en_i) begin
      rdata_o <= mem_r[raddr_i];
    end
  end
endmodule

module sobel_window_gen #(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 640,
  parameter int IMG_H_P = 480
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [WIDTH_P-1:0]   pix_i,
  input  logic                 valid_i,
`ifdef SOBEL_WINDOW_SOF_EN
  input  logic                 sof_i,
`endif
  output logic                 ready_o,
  output logic [9*WIDTH_P-1:0] window_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o
);
  localparam int CW = $clog2(IMG_W_P);
  localparam int RW = $clog2(IMG_H_P);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W_P - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H_P - 1);
  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic                 adv_s, acc_s, sof_hit_s, emit_s, last_s;
  logic [CW-1:0]        col_r, pos_col_s;
  logic [RW-1:0]        row_r, pos_row_s;
  logic [0:0]           state_r, pos_state_s;
  logic [WIDTH_P-1:0]   a_rdata_s, b_rdata_s;
  logic                 s1_v_r, s1_emit_r, s1_last_r;
  logic [WIDTH_P-1:0]   s1_pix_r;
  logic [CW-1:0]        s1_col_r;
  logic [2:0][3*WIDTH_P-1:0] sr_r;
  logic                 s2_v_r, s2_last_r;
  logic [9*WIDTH_P-1:0] win_s;

  assign adv_s   = ready_i | ~valid_o;
  assign ready_o = adv_s;
  assign acc_s   = valid_i & adv_s;

`ifdef SOBEL_WINDOW_SOF_EN
  assign sof_hit_s = acc_s & sof_i & ((col_r != {CW{1'b0}}) | (row_r != {RW{1'b0}}));
`else
  assign sof_hit_s = 1'b0;
`endif

  // Effective position of the pixel being accepted; a start-of-frame forces (0,0) in PRIME.
  always_comb begin
    pos_col_s   = col_r;
    pos_row_s   = row_r;
    pos_state_s = state_r;
    if (sof_hit_s) begin
      pos_col_s   = {CW{1'b0}};
      pos_row_s   = {RW{1'b0}};
      pos_state_s = ST_PRIME;
    end else begin
      pos_col_s   = col_r;
      pos_row_s   = row_r;
      pos_state_s = state_r;
    end
  end

  assign emit_s = (pos_state_s == ST_RUN) && (pos_col_s >= CW'(2));
  assign last_s = (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);

  // Raster position counters and PRIME/RUN state, advanced once per accepted pixel.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      col_r   <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
      state_r <= ST_PRIME;
    end else if (acc_s) begin
      if (pos_col_s == COL_LAST) begin
        col_r <= {CW{1'b0}};
        row_r <= (pos_row_s == ROW_LAST) ? {RW{1'b0}} : pos_row_s + RW'(1);
      end else begin
        col_r <= pos_col_s + CW'(1);
        row_r <= pos_row_s;
      end
      case (pos_state_s)
        ST_PRIME: state_r <= ((pos_row_s == RW'(1)) && (pos_col_s == COL_LAST)) ? ST_RUN : ST_PRIME;
        ST_RUN:   state_r <= last_s ? ST_PRIME : ST_RUN;
        default:  state_r <= ST_PRIME;
      endcase
    end
  end

  // Line A keeps row r-1; its old word moves to line B (row r-2) one stage later.
  sync_ram_block #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P), .AW_P(CW)) u_line_a (
    .clk_i   (clk_i),
    .we_i    (acc_s),
    .waddr_i (pos_col_s),
    .wdata_i (pix_i),
    .rd_en_i (acc_s),
    .raddr_i (pos_col_s),
    .rdata_o (a_rdata_s)
  );

  sync_ram_block #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P), .AW_P(CW)) u_line_b (
    .clk_i   (clk_i),
    .we_i    (adv_s & s1_v_r),
    .waddr_i (s1_col_r),
    .wdata_i (a_rdata_s),
    .rd_en_i (acc_s),
    .raddr_i (pos_col_s),
    .rdata_o (b_rdata_s)
  );

  // Stage 1: pixel and tags aligned with the line-memory read data.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      s1_v_r    <= 1'b0;
      s1_emit_r <= 1'b0;
      s1_last_r <= 1'b0;
      s1_pix_r  <= {WIDTH_P{1'b0}};
      s1_col_r  <= {CW{1'b0}};
    end else if (adv_s) begin
      s1_v_r    <= acc_s;
      s1_emit_r <= acc_s & emit_s;
      s1_last_r <= acc_s & last_s;
      if (acc_s) begin
        s1_pix_r <= pix_i;
        s1_col_r <= pos_col_s;
      end
    end
  end

  // Stage 2: horizontal shift of the 3-row column; not cleared at row wrap.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sr_r      <= {(9*WIDTH_P){1'b0}};
      s2_v_r    <= 1'b0;
      s2_last_r <= 1'b0;
    end else if (adv_s) begin
      if (s1_v_r) begin
        sr_r[0] <= sr_r[1];
        sr_r[1] <= sr_r[2];
        sr_r[2] <= {s1_pix_r, a_rdata_s, b_rdata_s};
      end
      s2_v_r    <= s1_v_r & s1_emit_r & ~sof_hit_s;
      s2_last_r <= s1_last_r;
    end
  end

  // Reorder column-major shift register into row-major window slots.
  always_comb begin
    win_s = {(9*WIDTH_P){1'b0}};
    for (int dc = 0; dc < 3; dc++) begin
      for (int dr = 0; dr < 3; dr++) begin
        win_s[WIDTH_P*(3*dr+dc) +: WIDTH_P] = sr_r[dc][WIDTH_P*dr +: WIDTH_P];
      end
    end
  end

  // Output register; holds while the downstream stalls.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_o  <= 1'b0;
      last_o   <= 1'b0;
      window_o <= {(9*WIDTH_P){1'b0}};
    end else if (adv_s) begin
      valid_o <= s2_v_r & ~sof_hit_s;
      last_o  <= s2_v_r & s2_last_r & ~sof_hit_s;
      if (s2_v_r) begin
        window_o <= win_s;
      end
    end
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 frame with pix = r*16 + c.
// Exercises reset, full frames, output stall, input gaps and mid-frame reset.

module tb_sobel_window_gen;
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [7:0]  pix_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [71:0] window_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        last_o;
`ifdef SOBEL_WINDOW_SOF_EN
  logic        sof_i = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc22_cyc = 0;
  int first_valid_cyc = 0;
  logic seen_valid = 1'b0;
  logic [71:0] win_q[$];
  logic        last_q[$];

  sobel_window_gen #(.WIDTH_P(8), .IMG_W_P(4), .IMG_H_P(4)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .pix_i    (pix_i),
    .valid_i  (valid_i),
`ifdef SOBEL_WINDOW_SOF_EN
    .sof_i    (sof_i),
`endif
    .ready_o  (ready_o),
    .window_o (window_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record transfers and accepts away from the active edge.
  always @(negedge clk_i) begin
    if (rstn_i && valid_o && ready_i) begin
      win_q.push_back(window_o);
      last_q.push_back(last_o);
    end
    if (rstn_i && valid_i && ready_o) acc_cnt++;
    if (valid_o && !seen_valid) begin
      seen_valid = 1'b1;
      first_valid_cyc = cyc;
    end
  end

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = 72'd0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[8*(3*dr+dc) +: 8] = 8'((r-2+dr)*16 + (c-2+dc));
    return w;
  endfunction

  task automatic send_pix(input logic [7:0] p, input logic sof);
    int n;
    pix_i = p;
    valid_i = 1'b1;
`ifdef SOBEL_WINDOW_SOF_EN
    sof_i = sof;
`endif
    n = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL accept_timeout: pixel %h not accepted within 200 cycles", p);
        break;
      end
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0;
`ifdef SOBEL_WINDOW_SOF_EN
    sof_i = 1'b0;
`endif
  endtask

  task automatic send_pixels(input int start, input int n, input int gap);
    for (int i = start; i < start + n; i++) begin
      send_pix(8'((i/4)*16 + (i%4)), 1'b0);
      if (i == 10) acc22_cyc = cyc;
      if (gap != 0) begin
        @(posedge clk_i); #1;
      end
    end
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic clear_q();
    win_q.delete();
    last_q.delete();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; ready_i = 1'b1;
    drain(3);
    rstn_i = 1'b1;
    for (int i = 0; i < 6; i++) send_pix(8'hEE, 1'b0);
    rstn_i = 1'b0;
    drain(1);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL reset_last: got %b want 0", last_o); end
    checks++; if (window_o !== 72'd0) begin failures++; $display("FAIL reset_window: got %h want 0", window_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    rstn_i = 1'b1;
    drain(1);
  endtask

  task automatic test_full_frame();
    logic [71:0] w;
    clear_q(); seen_valid = 1'b0; ready_i = 1'b1;
    send_pixels(0, 16, 0);
    drain(8);
    checks++; if (win_q.size() !== 4) begin failures++; $display("FAIL full_count: got %0d want 4", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      checks++; if (win_q[i] !== exp_win(2 + i/2, 2 + i%2)) begin failures++; $display("FAIL full_win%0d: got %h want %h", i, win_q[i], exp_win(2 + i/2, 2 + i%2)); end
      checks++; if (last_q[i] !== (i == 3)) begin failures++; $display("FAIL full_last%0d: got %b want %b", i, last_q[i], (i == 3)); end
    end
    if (win_q.size() == 4) begin
      w = win_q[0];
      checks++; if (w[7:0] !== 8'h00 || w[39:32] !== 8'h11 || w[71:64] !== 8'h22) begin failures++; $display("FAIL first_slots: got k0=%h k4=%h k8=%h want 00 11 22", w[7:0], w[39:32], w[71:64]); end
      w = win_q[3];
      checks++; if (w[7:0] !== 8'h11 || w[71:64] !== 8'h33) begin failures++; $display("FAIL last_slots: got k0=%h k8=%h want 11 33", w[7:0], w[71:64]); end
    end
    checks++; if (first_valid_cyc - acc22_cyc !== 2) begin failures++; $display("FAIL latency: got %0d want 2", first_valid_cyc - acc22_cyc); end
  endtask

  task automatic test_stall();
    int n, a0;
    clear_q(); ready_i = 1'b0;
    fork
      send_pixels(0, 16, 0);
    join_none
    n = 0;
    do begin
      @(negedge clk_i); n++;
    end while (!valid_o && n < 100);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL stall_wait: valid_o got %b want 1", valid_o); end
    a0 = acc_cnt;
    repeat (5) begin
      @(negedge clk_i);
      checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", valid_o); end
      checks++; if (window_o !== exp_win(2, 2)) begin failures++; $display("FAIL stall_window: got %h want %h", window_o, exp_win(2, 2)); end
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL stall_ready: got %b want 0", ready_o); end
      checks++; if (acc_cnt !== a0) begin failures++; $display("FAIL stall_accept: got %0d want %0d", acc_cnt, a0); end
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    wait fork;
    drain(8);
    checks++; if (win_q.size() !== 4) begin failures++; $display("FAIL stall_count: got %0d want 4", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      checks++; if (win_q[i] !== exp_win(2 + i/2, 2 + i%2)) begin failures++; $display("FAIL stall_win%0d: got %h want %h", i, win_q[i], exp_win(2 + i/2, 2 + i%2)); end
    end
  endtask

  task automatic test_valid_gaps();
    clear_q(); ready_i = 1'b1;
    send_pixels(0, 16, 1);
    send_pixels(0, 8, 1);
    drain(6);
    checks++; if (win_q.size() !== 4) begin failures++; $display("FAIL gaps_prime: got %0d windows want 4", win_q.size()); end
    send_pixels(8, 8, 1);
    drain(8);
    checks++; if (win_q.size() !== 8) begin failures++; $display("FAIL gaps_count: got %0d want 8", win_q.size()); end
    for (int i = 0; i < win_q.size() && i < 8; i++) begin
      checks++; if (win_q[i] !== exp_win(2 + (i%4)/2, 2 + i%2)) begin failures++; $display("FAIL gaps_win%0d: got %h want %h", i, win_q[i], exp_win(2 + (i%4)/2, 2 + i%2)); end
      checks++; if (last_q[i] !== ((i%4) == 3)) begin failures++; $display("FAIL gaps_last%0d: got %b want %b", i, last_q[i], ((i%4) == 3)); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    clear_q(); ready_i = 1'b1;
    send_pixels(0, 16, 0);
    n = 0;
    while (win_q.size() < 3 && n < 50) begin
      @(posedge clk_i); #1; n++;
    end
    checks++; if (win_q.size() < 3) begin failures++; $display("FAIL midrst_wait: got %0d windows want 3", win_q.size()); end
    rstn_i = 1'b0;
    drain(1);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
    checks++; if (window_o !== 72'd0) begin failures++; $display("FAIL midrst_window: got %h want 0", window_o); end
    rstn_i = 1'b1;
    drain(1);
    clear_q();
    send_pixels(0, 16, 0);
    drain(8);
    checks++; if (win_q.size() !== 4) begin failures++; $display("FAIL midrst_count: got %0d want 4", win_q.size()); end
    if (win_q.size() > 0) begin
      checks++; if (win_q[0][7:0] !== 8'h00) begin failures++; $display("FAIL midrst_k0: got %h want 00", win_q[0][7:0]); end
    end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      checks++; if (win_q[i] !== exp_win(2 + i/2, 2 + i%2)) begin failures++; $display("FAIL midrst_win%0d: got %h want %h", i, win_q[i], exp_win(2 + i/2, 2 + i%2)); end
    end
  endtask

`ifdef SOBEL_WINDOW_SOF_EN
  task automatic test_sof();
    clear_q(); ready_i = 1'b1;
    send_pixels(0, 9, 0);
    send_pix(8'h00, 1'b1);
    send_pixels(1, 15, 0);
    drain(8);
    checks++; if (win_q.size() !== 4) begin failures++; $display("FAIL sof_count: got %0d want 4", win_q.size()); end
    if (win_q.size() > 0) begin
      checks++; if (win_q[0][7:0] !== 8'h00) begin failures++; $display("FAIL sof_k0: got %h want 00", win_q[0][7:0]); end
    end
    for (int i = 0; i < win_q.size() && i < 4; i++) begin
      checks++; if (win_q[i] !== exp_win(2 + i/2, 2 + i%2)) begin failures++; $display("FAIL sof_win%0d: got %h want %h", i, win_q[i], exp_win(2 + i/2, 2 + i%2)); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_valid_gaps();
    test_mid_reset();
`ifdef SOBEL_WINDOW_SOF_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
